// File: rtl/cla_pipelined_adder_pkg.sv
// ---------------------------------------------------------------------------
// cla_pipelined_adder_pkg
// Shared definitions (the cla_defs set) for the pipelined carry-lookahead
// adder: the lookahead group width and helpers that derive the group count
// and validate the operand width at elaboration.
// No ports (package).
// ---------------------------------------------------------------------------
package cla_pipelined_adder_pkg;

  // Width of one lookahead group; the group P*/G* logic is written for 4 bits
  localparam int GROUP_W = 4;

  // Number of lookahead groups for a given operand width
  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction

  // Operand width must be a whole number of groups, 4..64 bits
  function automatic bit width_ok(input int width);
    return ((width % GROUP_W) == 0) && (width >= 4) && (width <= 64);
  endfunction

endpackage

// File: rtl/cla_group_pg.sv
// ---------------------------------------------------------------------------
// cla_group_pg
// Block propagate / generate for one 4-bit lookahead group.
// Ports:
//   a, b   in   4   operand slices of this group
//   p_blk  out  1   group propagate P* = &(a^b)
//   g_blk  out  1   group generate  G* = g3 | p3g2 | p3p2g1 | p3p2p1g0
// ---------------------------------------------------------------------------
module cla_group_pg
  import cla_pipelined_adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  output logic               p_blk,
  output logic               g_blk
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;

  // Per-bit propagate and generate
  assign p = a ^ b;
  assign g = a & b;

  // Two-level group terms so the group carry never ripples through the bits
  assign p_blk = &p;
  assign g_blk = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_pipelined_adder.sv
// ---------------------------------------------------------------------------
// cla_pipelined_adder
// Two-stage pipelined WIDTH-bit carry-lookahead adder built from 4-bit groups.
// Stage 1 registers the operands together with the per-group P*/G*; stage 2
// runs the lookahead carry chain over the groups, forms the bit carries
// inside each group and registers sum/cout. Valid/ready on both sides, full
// throughput, no bubbles.
// Optional feature macro: CLA_FLAGS_EN adds registered ovf/zero outputs.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/cin valid this cycle
//   in_ready   out  1      adder accepts input this cycle
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  a+b+cin mod 2^WIDTH
//   cout       out  1      carry out of the MSB
//   ovf        out  1      signed overflow (CLA_FLAGS_EN only)
//   zero       out  1      sum == 0        (CLA_FLAGS_EN only)
// ---------------------------------------------------------------------------
module cla_pipelined_adder
  import cla_pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_FLAGS_EN
  output logic             ovf,
  output logic             zero,
`endif
  output logic             cout
);

  localparam int NG = num_groups(WIDTH);

  // Reject widths that do not split into whole groups
  if (!width_ok(WIDTH)) begin : g_width_check
    $error("cla_pipelined_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  logic             adv1;
  logic             adv2;
  logic [NG-1:0]    grp_p_in;
  logic [NG-1:0]    grp_g_in;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [NG-1:0]    s1_grp_p;
  logic [NG-1:0]    s1_grp_g;

  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NG:0]      grp_carry;
  logic [WIDTH-1:0] bit_carry;
  logic [WIDTH-1:0] sum_next;

  // A stage may take new data when it is empty or its contents move on
  // this edge, so a full pipeline still accepts one item per cycle
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Group P*/G* on the incoming operands, captured with them in stage 1
  for (genvar k = 0; k < NG; k++) begin : g_group
    cla_group_pg u_group_pg (
      .a     (a[GROUP_W*k +: GROUP_W]),
      .b     (b[GROUP_W*k +: GROUP_W]),
      .p_blk (grp_p_in[k]),
      .g_blk (grp_g_in[k])
    );
  end

  // Stage 1: operand and group P*/G* registers. Data only loads on a real
  // transfer; the valid bit drains to 0 when the stage moves on empty-handed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_grp_p <= '0;
      s1_grp_g <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_cin   <= cin;
        s1_grp_p <= grp_p_in;
        s1_grp_g <= grp_g_in;
      end
    end
  end

  assign s1_p = s1_a ^ s1_b;
  assign s1_g = s1_a & s1_b;

  // Stage 2 lookahead: group carries come only from the registered P*/G*,
  // then each group expands its own carry-in into bit carries locally
  always_comb begin
    logic bc;
    grp_carry    = '0;
    bit_carry    = '0;
    bc           = 1'b0;
    grp_carry[0] = s1_cin;
    for (int k = 0; k < NG; k++) begin
      grp_carry[k+1] = s1_grp_g[k] | (s1_grp_p[k] & grp_carry[k]);
    end
    for (int k = 0; k < NG; k++) begin
      bc = grp_carry[k];
      for (int j = 0; j < GROUP_W; j++) begin
        bit_carry[GROUP_W*k+j] = bc;
        bc = s1_g[GROUP_W*k+j] | (s1_p[GROUP_W*k+j] & bc);
      end
    end
  end

  assign sum_next = s1_p ^ bit_carry;

  // Stage 2 result registers; held unchanged while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef CLA_FLAGS_EN
      ovf       <= 1'b0;
      zero      <= 1'b0;
`endif
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_next;
        cout <= grp_carry[NG];
`ifdef CLA_FLAGS_EN
        // Signed overflow: carry into the MSB differs from carry out of it
        ovf  <= grp_carry[NG] ^ bit_carry[WIDTH-1];
        zero <= ~|sum_next;
`endif
      end
    end
  end

endmodule
